// File: rtl/adi_spi_cfg_seq_7_8bit.sv
// Power-up register-init sequencer for the ADI 7-bit-addr/8-bit-data SPI driver.
// Optional `CFG_READBACK_VERIFY_EN: read back and compare every written entry.
module adi_spi_cfg_seq_7_8bit #(
  parameter int CLK_FRE     = 100_000_000,
  parameter int PWR_WAIT_US = 1000,
  parameter int TABLE_LEN   = 16,
  parameter int TMO_CYC     = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic [7:0]  tbl_idx,
  input  logic [14:0] tbl_entry,
  output logic        user_wr_en,
  output logic [6:0]  user_wr_addr,
  output logic [7:0]  user_wr_data,
  output logic        user_rd_en,
  output logic [6:0]  user_rd_addr,
  input  logic [7:0]  user_rd_data,
  input  logic        user_op_busy,
  input  logic        user_wr_vild,
  input  logic        user_rd_vild,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  err_idx
);

  localparam int PWR_CYC = CLK_FRE / 1_000_000 * PWR_WAIT_US;
  localparam logic [31:0] PWR_LAST = 32'(PWR_CYC - 1);
  localparam logic [31:0] TMO_LAST = 32'(TMO_CYC - 1);
  localparam logic [7:0]  LAST_IDX = 8'(TABLE_LEN - 1);

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_FETCH,
    S_LATCH,
    S_ISSUE_WR,
    S_WAIT_WR,
    S_ISSUE_RD,
    S_WAIT_RD,
    S_CHECK,
    S_NEXT,
    S_DONE,
    S_ERR,
    S_IDLE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] cnt;
  logic [14:0] entry_q;
  logic        tmo_hit;
  logic        ld_entry;
  logic        issue_wr;
  logic        idx_inc;
  logic        restart;
  logic        set_err;
  logic        wr_en_q;
  logic [6:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

`ifdef CFG_READBACK_VERIFY_EN
  logic        issue_rd;
  logic        ld_rd;
  logic        rd_en_q;
  logic [6:0]  rd_addr_q;
  logic [7:0]  rd_q;
`endif

  assign tmo_hit = (cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_PWR_WAIT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    ld_entry = 1'b0;
    issue_wr = 1'b0;
    idx_inc  = 1'b0;
    restart  = 1'b0;
    set_err  = 1'b0;
`ifdef CFG_READBACK_VERIFY_EN
    issue_rd = 1'b0;
    ld_rd    = 1'b0;
`endif
    unique case (state)
      S_PWR_WAIT: begin
        if (cnt == PWR_LAST) state_n = S_FETCH;
      end
      S_FETCH: state_n = S_LATCH;
      S_LATCH: begin
        ld_entry = 1'b1;
        state_n  = S_ISSUE_WR;
      end
      S_ISSUE_WR: begin
        if (!user_op_busy) begin
          issue_wr = 1'b1;
          state_n  = S_WAIT_WR;
        end
      end
      S_WAIT_WR: begin
        if (user_wr_vild) begin
`ifdef CFG_READBACK_VERIFY_EN
          state_n = S_ISSUE_RD;
`else
          state_n = S_NEXT;
`endif
        end else if (tmo_hit) begin
          set_err = 1'b1;
          state_n = S_ERR;
        end
      end
`ifdef CFG_READBACK_VERIFY_EN
      S_ISSUE_RD: begin
        if (!user_op_busy) begin
          issue_rd = 1'b1;
          state_n  = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (user_rd_vild) begin
          ld_rd   = 1'b1;
          state_n = S_CHECK;
        end else if (tmo_hit) begin
          set_err = 1'b1;
          state_n = S_ERR;
        end
      end
      S_CHECK: begin
        if (rd_q != wr_data_q) begin
          set_err = 1'b1;
          state_n = S_ERR;
        end else begin
          state_n = S_NEXT;
        end
      end
`endif
      S_NEXT: begin
        if (tbl_idx == LAST_IDX) begin
          state_n = S_DONE;
        end else begin
          idx_inc = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_DONE, S_ERR, S_IDLE: begin
        if (cfg_start) begin
          restart = 1'b1;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Wait counter restarts on every state change, so it measures
  // time spent in the current waiting state only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_idx   <= '0;
      err_idx   <= '0;
      entry_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= issue_wr;
      if (ld_entry) entry_q <= tbl_entry;
      if (issue_wr) begin
        wr_addr_q <= {2'b00, entry_q[12:8]};
        wr_data_q <= entry_q[7:0];
      end
      if (idx_inc) tbl_idx <= tbl_idx + 8'd1;
      if (restart) begin
        tbl_idx <= '0;
        err_idx <= '0;
      end
      if (set_err) err_idx <= tbl_idx;
    end
  end

`ifdef CFG_READBACK_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_q      <= '0;
    end else begin
      rd_en_q <= issue_rd;
      if (issue_rd) rd_addr_q <= wr_addr_q;
      if (ld_rd) rd_q <= user_rd_data;
    end
  end

  assign user_rd_en   = rd_en_q;
  assign user_rd_addr = rd_addr_q;
`else
  logic unused_rd;
  assign unused_rd    = ^{user_rd_data, user_rd_vild};
  assign user_rd_en   = 1'b0;
  assign user_rd_addr = 7'h00;
`endif

  logic unused_n1n0;
  assign unused_n1n0 = ^entry_q[14:13];

  assign user_wr_en   = wr_en_q;
  assign user_wr_addr = wr_addr_q;
  assign user_wr_data = wr_data_q;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign cfg_busy = rst_n &
    !(state == S_DONE || state == S_ERR || state == S_IDLE);
  assign cfg_done = (state == S_DONE);
  assign cfg_err  = (state == S_ERR);

endmodule

// File: tb/tb_adi_spi_cfg_seq_7_8bit.sv
// Bench for adi_spi_cfg_seq_7_8bit: random tables, driver model, scoreboard.
// Readback cases run only when CFG_READBACK_VERIFY_EN is defined.
module tb_adi_spi_cfg_seq_7_8bit;

  localparam int CLK_FRE = 1_000_000;
  localparam int PWR_US  = 40;
  localparam int PWR_CYC = CLK_FRE / 1_000_000 * PWR_US;
  localparam int TLEN    = 4;
  localparam int TMO     = 64;
  localparam int RSP_DLY = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  tbl_idx;
  logic [14:0] tbl_entry = '0;
  logic        user_wr_en;
  logic [6:0]  user_wr_addr;
  logic [7:0]  user_wr_data;
  logic        user_rd_en;
  logic [6:0]  user_rd_addr;
  logic [7:0]  user_rd_data = '0;
  logic        user_op_busy = 1'b0;
  logic        user_wr_vild = 1'b0;
  logic        user_rd_vild = 1'b0;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [7:0]  err_idx;

  adi_spi_cfg_seq_7_8bit #(
    .CLK_FRE(CLK_FRE),
    .PWR_WAIT_US(PWR_US),
    .TABLE_LEN(TLEN),
    .TMO_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_start(cfg_start),
    .tbl_idx(tbl_idx),
    .tbl_entry(tbl_entry),
    .user_wr_en(user_wr_en),
    .user_wr_addr(user_wr_addr),
    .user_wr_data(user_wr_data),
    .user_rd_en(user_rd_en),
    .user_rd_addr(user_rd_addr),
    .user_rd_data(user_rd_data),
    .user_op_busy(user_op_busy),
    .user_wr_vild(user_wr_vild),
    .user_rd_vild(user_rd_vild),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err),
    .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cyc = 0;
  int run_id = 0;
  int drop_idx = -1;
  int bad_idx = -1;

  logic [14:0] tbl [TLEN];
  logic [14:0] exp_wr [$];
  logic [6:0]  exp_rd [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous table ROM: data follows the address by one clock.
  always @(posedge clk) tbl_entry <= tbl[tbl_idx[1:0]];

  // Reference model: each entry yields one write with N1N0 cleared.
  task automatic push_run(int nw, int nr);
    exp_wr.delete();
    exp_rd.delete();
    for (int i = 0; i < nw; i++)
      exp_wr.push_back({tbl[i][14:8] & 7'h1F, tbl[i][7:0]});
    for (int i = 0; i < nr; i++)
      exp_rd.push_back(tbl[i][14:8] & 7'h1F);
  endtask

  // Driver model: answers each request RSP_DLY clocks later.
  initial begin
    int cd = 0;
    int cd_rd = 0;
    int n_wr = 0;
    int last_n = 0;
    int seen_run = 0;
    logic [7:0] last_data = '0;
    logic [7:0] rd_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cd = 0;
        cd_rd = 0;
        n_wr = 0;
        user_wr_vild = 1'b0;
        user_rd_vild = 1'b0;
        user_op_busy = 1'b0;
      end else begin
        if (seen_run != run_id) begin
          seen_run = run_id;
          n_wr = 0;
        end
        user_wr_vild = 1'b0;
        user_rd_vild = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) user_wr_vild = 1'b1;
        end
        if (cd_rd > 0) begin
          cd_rd--;
          if (cd_rd == 0) begin
            user_rd_vild = 1'b1;
            user_rd_data = rd_val;
          end
        end
        if (user_wr_en) begin
          if (n_wr != drop_idx) cd = RSP_DLY;
          last_data = user_wr_data;
          last_n = n_wr;
          n_wr++;
        end
        if (user_rd_en) begin
          cd_rd = RSP_DLY;
          rd_val = (last_n == bad_idx) ? 8'h55 : last_data;
        end
        user_op_busy = (cd > 0) || (cd_rd > 0);
      end
    end
  end

  // Monitor: pops expected transactions whenever the DUT issues one.
  always @(negedge clk) begin
    logic [14:0] e;
    logic [6:0] ra;
    if (rst_n) begin
      chk("done_err_excl", 32'(cfg_done & cfg_err), 32'd0);
      if (user_wr_en) begin
        wr_cyc = cyc;
        if (exp_wr.size() == 0) begin
          chk("wr_extra", 32'd1, 32'd0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(user_wr_addr), 32'(e[14:8]));
          chk("wr_data", 32'(user_wr_data), 32'(e[7:0]));
        end
      end
      if (user_rd_en) begin
`ifdef CFG_READBACK_VERIFY_EN
        if (exp_rd.size() == 0) begin
          chk("rd_extra", 32'd1, 32'd0);
        end else begin
          ra = exp_rd.pop_front();
          chk("rd_addr", 32'(user_rd_addr), 32'(ra));
        end
`else
        chk("rd_en_tied", 32'(user_rd_en), 32'd0);
`endif
      end
    end
  end

  task automatic pulse_start();
    run_id++;
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_wr(output int k);
    k = 0;
    while (!user_wr_en && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!user_wr_en) chk("wr_wait_tmo", 32'd1, 32'd0);
  endtask

  task automatic wait_end();
    int k = 0;
    while (!(cfg_done || cfg_err) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!(cfg_done || cfg_err)) chk("end_tmo", 32'd1, 32'd0);
  endtask

  task automatic rand_tbl();
    for (int i = 0; i < TLEN; i++) tbl[i] = 15'($urandom);
  endtask

  function automatic logic [31:0] outs();
    return 32'({user_wr_en, user_wr_addr, user_wr_data,
                user_rd_en, user_rd_addr, cfg_busy, cfg_done,
                cfg_err}) | 32'(err_idx) | 32'(tbl_idx);
  endfunction

  initial begin
    int k;
    rand_tbl();
    tbl[0] = {7'h65, 8'hAA};
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 32'd0);
    push_run(TLEN, TLEN);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pwr_busy", 32'(cfg_busy), 32'd1);
    chk("pwr_rd_addr", 32'(user_rd_addr), 32'd0);
    wait_wr(k);
    chk("pwr_wait_len", 32'(k >= PWR_CYC && k <= PWR_CYC + 10), 32'd1);
    chk("n1n0_addr", 32'(user_wr_addr), 32'h05);
    chk("n1n0_data", 32'(user_wr_data), 32'hAA);
    wait_end();
    chk("run1_done", 32'(cfg_done), 32'd1);
    chk("run1_busy", 32'(cfg_busy), 32'd0);
    chk("run1_idx", 32'(tbl_idx), 32'(TLEN - 1));
    chk("run1_left", 32'(exp_wr.size()), 32'd0);

    rand_tbl();
    push_run(TLEN, TLEN);
    pulse_start();
    chk("rerun_done_clr", 32'(cfg_done), 32'd0);
    chk("rerun_idx0", 32'(tbl_idx), 32'd0);
    chk("rerun_busy", 32'(cfg_busy), 32'd1);
    wait_wr(k);
    chk("rerun_no_pwr", 32'(k < PWR_CYC), 32'd1);
    repeat (10) @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_end();
    chk("run2_done", 32'(cfg_done), 32'd1);
    chk("run2_left", 32'(exp_wr.size()), 32'd0);

    rand_tbl();
    drop_idx = 2;
    push_run(3, 2);
    pulse_start();
    wait_end();
    chk("tmo_err", 32'(cfg_err), 32'd1);
    chk("tmo_done", 32'(cfg_done), 32'd0);
    chk("tmo_busy", 32'(cfg_busy), 32'd0);
    chk("tmo_err_idx", 32'(err_idx), 32'd2);
    chk("tmo_cycles", 32'(cyc - wr_cyc), 32'(TMO));
    chk("tmo_left", 32'(exp_wr.size()), 32'd0);
    drop_idx = -1;

`ifdef CFG_READBACK_VERIFY_EN
    rand_tbl();
    tbl[1][7:0] = 8'h5A;
    bad_idx = 1;
    push_run(2, 2);
    pulse_start();
    chk("err_clr", 32'(cfg_err), 32'd0);
    chk("err_idx_clr", 32'(err_idx), 32'd0);
    wait_end();
    chk("rb_err", 32'(cfg_err), 32'd1);
    chk("rb_err_idx", 32'(err_idx), 32'd1);
    chk("rb_rd_left", 32'(exp_rd.size()), 32'd0);
    bad_idx = -1;
    push_run(TLEN, TLEN);
    pulse_start();
    wait_end();
    chk("rb_ok_done", 32'(cfg_done), 32'd1);
    chk("rb_ok_rd_left", 32'(exp_rd.size()), 32'd0);
`endif

    rand_tbl();
    tbl[3] = {7'h13, 8'hC3};
    push_run(TLEN, TLEN);
    pulse_start();
    chk("err_clr2", 32'(cfg_err | cfg_done), 32'd0);
    k = 0;
    while (exp_wr.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached", 32'(exp_wr.size()), 32'd0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_outs", outs(), 32'd0);
    push_run(TLEN, TLEN);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_wr(k);
    chk("mid_pwr_wait", 32'(k >= PWR_CYC), 32'd1);
    wait_end();
    chk("mid_done", 32'(cfg_done), 32'd1);
    chk("mid_left", 32'(exp_wr.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
